// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg
// Shared definitions for the core's data memory and its load path.
//   - Load/store length encodings (LEN_*)
//   - Default storage depth
//   - Alignment helper used when MISALIGN_TRAP_EN is defined
package rv_mem_pkg;

  localparam logic [1:0] LEN_NONE = 2'd0;
  localparam logic [1:0] LEN_BYTE = 2'd1;
  localparam logic [1:0] LEN_HALF = 2'd2;
  localparam logic [1:0] LEN_WORD = 2'd3;

  localparam int DEF_DEPTH_BYTES = 1024;

  // Half accesses need bit 0 clear, word accesses need bits 1:0 clear.
  // No-access and byte lengths can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] len,
                                         input logic [1:0] addr_lo);
    return ((len == LEN_HALF) && addr_lo[0]) ||
           ((len == LEN_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend
// Turns the four gathered load bytes into the 32-bit register value:
// selects the low byte/half/word and sign- or zero-extends it.
// Ports:
//   i_raw    [31:0] gathered bytes, {b[a+3], b[a+2], b[a+1], b[a]}
//   i_len    [1:0]  load length (LEN_NONE returns 0)
//   i_signed        1 = sign-extend byte/half, ignored for word
//   o_data   [31:0] extended load result
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_len,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic w_byte_fill;
  logic w_half_fill;

  assign w_byte_fill = i_signed & i_raw[7];
  assign w_half_fill = i_signed & i_raw[15];

  always_comb begin
    o_data = '0;
    case (i_len)
      LEN_BYTE: o_data = {{24{w_byte_fill}}, i_raw[7:0]};
      LEN_HALF: o_data = {{16{w_half_fill}}, i_raw[15:0]};
      LEN_WORD: o_data = i_raw;
      default:  o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// data_memory
// Byte-addressable little-endian data memory for the single-cycle core.
// One combinational read port, one write port clocked on SYS_clk rising.
// Upper address bits alias; multi-byte accesses wrap around the array.
// Optional build macro: MISALIGN_TRAP_EN adds MEM_misaligned, suppresses
// misaligned stores and forces misaligned loads to 0.
// Ports:
//   SYS_clk            system clock
//   SYS_reset          async active-low reset, clears the whole array
//   MEM_write_length   0 none / 1 byte / 2 half / 3 word
//   MEM_read_length    0 none (reads 0) / 1 byte / 2 half / 3 word
//   MEM_read_signed    sign-extend byte/half loads
//   MEM_write_data     store data, low bytes used for narrow stores
//   MEM_write_address  store byte address
//   MEM_read_address   load byte address
//   MEM_read_data      load result
//   MEM_misaligned     (MISALIGN_TRAP_EN only) misaligned read or write
module data_memory
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int ADDR_BITS   = $clog2(DEPTH_BYTES)
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [1:0]  MEM_write_length,
  input  logic [1:0]  MEM_read_length,
  input  logic        MEM_read_signed,
  input  logic [31:0] MEM_write_data,
  input  logic [31:0] MEM_write_address,
  input  logic [31:0] MEM_read_address,
  output logic [31:0] MEM_read_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        MEM_misaligned
`endif
);

  logic [7:0]           r_mem [DEPTH_BYTES];

  logic [ADDR_BITS-1:0] w_wr_base;
  logic [ADDR_BITS-1:0] w_rd_base;
  logic [ADDR_BITS-1:0] w_wr_idx [4];
  logic [ADDR_BITS-1:0] w_rd_idx [4];
  logic [1:0]           w_wr_len;
  logic [1:0]           w_rd_len;
  logic [3:0]           w_wr_en;
  logic [31:0]          w_rd_raw;
  logic                 w_unused_addr;

  assign w_wr_base = MEM_write_address[ADDR_BITS-1:0];
  assign w_rd_base = MEM_read_address[ADDR_BITS-1:0];

  // Upper address bits only alias back onto the array.
  assign w_unused_addr = ^{MEM_write_address[31:ADDR_BITS],
                           MEM_read_address[31:ADDR_BITS]};

  // Index arithmetic is ADDR_BITS wide, so the carry drops out and
  // multi-byte accesses wrap modulo DEPTH_BYTES.
  for (genvar k = 0; k < 4; k++) begin : g_idx
    assign w_wr_idx[k] = w_wr_base + ADDR_BITS'(k);
    assign w_rd_idx[k] = w_rd_base + ADDR_BITS'(k);
  end

`ifdef MISALIGN_TRAP_EN
  logic w_wr_misaligned;
  logic w_rd_misaligned;

  assign w_wr_misaligned = is_misaligned(MEM_write_length, MEM_write_address[1:0]);
  assign w_rd_misaligned = is_misaligned(MEM_read_length, MEM_read_address[1:0]);
  assign MEM_misaligned  = w_wr_misaligned | w_rd_misaligned;

  // A trapped access degrades to "no access": the store is dropped and
  // the load takes the LEN_NONE path, which returns 0.
  assign w_wr_len = w_wr_misaligned ? LEN_NONE : MEM_write_length;
  assign w_rd_len = w_rd_misaligned ? LEN_NONE : MEM_read_length;
`else
  assign w_wr_len = MEM_write_length;
  assign w_rd_len = MEM_read_length;
`endif

  always_comb begin
    w_wr_en    = 4'b0000;
    w_wr_en[0] = (w_wr_len != LEN_NONE);
    w_wr_en[1] = (w_wr_len == LEN_HALF) || (w_wr_len == LEN_WORD);
    w_wr_en[2] = (w_wr_len == LEN_WORD);
    w_wr_en[3] = (w_wr_len == LEN_WORD);
  end

  // Reset clears every byte asynchronously; a store pending at the
  // moment reset asserts is simply lost.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_wr_en[k]) begin
          r_mem[w_wr_idx[k]] <= MEM_write_data[8*k +: 8];
        end
      end
    end
  end

  // Reads see the registered array only; there is no write bypass.
  assign w_rd_raw = {r_mem[w_rd_idx[3]], r_mem[w_rd_idx[2]],
                     r_mem[w_rd_idx[1]], r_mem[w_rd_idx[0]]};

  load_extend u_load_extend (
    .i_raw    (w_rd_raw),
    .i_len    (w_rd_len),
    .i_signed (MEM_read_signed),
    .o_data   (MEM_read_data)
  );

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
// Self-checking bench for data_memory (default build). Directed scenarios
// use constant expectations; the random scenario compares against a plain
// byte-array reference model.
module tb_data_memory;

  logic        SYS_clk;
  logic        SYS_reset;
  logic [1:0]  MEM_write_length;
  logic [1:0]  MEM_read_length;
  logic        MEM_read_signed;
  logic [31:0] MEM_write_data;
  logic [31:0] MEM_write_address;
  logic [31:0] MEM_read_address;
  logic [31:0] MEM_read_data;
`ifdef MISALIGN_TRAP_EN
  logic        MEM_misaligned;
`endif

  int errors = 0;
  int checks = 0;

  byte unsigned model [1024];

  data_memory dut (
    .SYS_clk           (SYS_clk),
    .SYS_reset         (SYS_reset),
    .MEM_write_length  (MEM_write_length),
    .MEM_read_length   (MEM_read_length),
    .MEM_read_signed   (MEM_read_signed),
    .MEM_write_data    (MEM_write_data),
    .MEM_write_address (MEM_write_address),
    .MEM_read_address  (MEM_read_address),
    .MEM_read_data     (MEM_read_data)
`ifdef MISALIGN_TRAP_EN
    ,
    .MEM_misaligned    (MEM_misaligned)
`endif
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] exp;
    string       name;
  } rd_t;

  function automatic int nbytes(input logic [1:0] len);
    case (len)
      2'd1: return 1;
      2'd2: return 2;
      2'd3: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [1:0] len);
    int unsigned d = data;
    for (int k = 0; k < nbytes(len); k++)
      model[(int'(addr % 1024) + k) % 1024] = byte'((d >> (8 * k)) & 32'hFF);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] len,
                                             input logic sgn);
    longint v = 0;
    int n = nbytes(len);
    for (int k = 0; k < n; k++)
      v = v + (longint'(model[(int'(addr % 1024) + k) % 1024]) << (8 * k));
    if (sgn && (n == 1 || n == 2) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] len);
    @(negedge SYS_clk);
    MEM_write_address = addr;
    MEM_write_data    = data;
    MEM_write_length  = len;
    @(posedge SYS_clk);
    #1;
    MEM_write_length = 2'd0;
    model_store(addr, data, len);
  endtask

  task automatic set_read(input logic [31:0] addr, input logic [1:0] len, input logic sgn);
    @(negedge SYS_clk);
    MEM_read_address = addr;
    MEM_read_length  = len;
    MEM_read_signed  = sgn;
    #1;
  endtask

  task automatic run_table(input rd_t t []);
    foreach (t[i]) begin
      set_read(t[i].addr, t[i].len, t[i].sgn);
      checks++;
      if (MEM_read_data !== t[i].exp) begin
        errors++;
        $display("FAIL %s: got %08h expected %08h", t[i].name, MEM_read_data, t[i].exp);
      end
    end
  endtask

  task automatic test_reset();
    rd_t t [];
    SYS_reset = 1'b0;
    model_clear();
    // A store attempted while reset is held must be ignored.
    @(negedge SYS_clk);
    MEM_write_address = 32'd0;
    MEM_write_data    = 32'hDEADBEEF;
    MEM_write_length  = 2'd3;
    MEM_read_address  = 32'd0;
    MEM_read_length   = 2'd3;
    @(posedge SYS_clk);
    #1;
    checks++;
    if (MEM_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_write_ignored: got %08h expected 00000000", MEM_read_data);
    end
    @(negedge SYS_clk);
    MEM_write_length = 2'd0;
    SYS_reset = 1'b1;
    t = '{'{32'd0, 2'd3, 1'b0, 32'h0, "reset_lw0"},
          '{32'd4, 2'd3, 1'b0, 32'h0, "reset_lw4"},
          '{32'd1020, 2'd3, 1'b0, 32'h0, "reset_lw1020"}};
    run_table(t);
  endtask

  task automatic test_word_narrow();
    rd_t t [];
    do_store(32'd8, 32'h12345678, 2'd3);
    t = '{'{32'd8, 2'd3, 1'b0, 32'h12345678, "lw8"},
          '{32'd8, 2'd1, 1'b0, 32'h00000078, "lbu8"},
          '{32'd11, 2'd1, 1'b0, 32'h00000012, "lbu11"},
          '{32'd10, 2'd2, 1'b0, 32'h00001234, "lhu10"},
          '{32'd8, 2'd0, 1'b1, 32'h00000000, "len0_read"}};
    run_table(t);
  endtask

  task automatic test_sign_ext();
    rd_t t [];
    do_store(32'd4, 32'h77665580, 2'd1);
    do_store(32'd6, 32'h1234BEEF, 2'd2);
    t = '{'{32'd4, 2'd1, 1'b1, 32'hFFFFFF80, "lb4"},
          '{32'd4, 2'd1, 1'b0, 32'h00000080, "lbu4"},
          '{32'd6, 2'd2, 1'b1, 32'hFFFFBEEF, "lh6"},
          '{32'd6, 2'd2, 1'b0, 32'h0000BEEF, "lhu6"},
          '{32'd4, 2'd3, 1'b1, 32'hBEEF0080, "lw4_signed_ignored"}};
    run_table(t);
  endtask

  task automatic test_partial();
    rd_t t [];
    do_store(32'd16, 32'hAABBCCDD, 2'd3);
    do_store(32'd17, 32'hFFFFFF11, 2'd1);
    do_store(32'd16, 32'hFFFFFFFF, 2'd0);
    t = '{'{32'd16, 2'd3, 1'b0, 32'hAABB11DD, "lw16_partial"},
          '{32'd12, 2'd3, 1'b0, 32'h00000000, "lw12_untouched"},
          '{32'd20, 2'd3, 1'b0, 32'h00000000, "lw20_untouched"}};
    run_table(t);
  endtask

  task automatic test_alias_wrap();
    rd_t t [];
    do_store(32'd1032, 32'hCAFEF00D, 2'd3);
    do_store(32'd1022, 32'h01020304, 2'd3);
    t = '{'{32'd8, 2'd3, 1'b0, 32'hCAFEF00D, "alias_lw8"},
          '{32'h8000_0408, 2'd3, 1'b0, 32'hCAFEF00D, "alias_high_lw"},
          '{32'd1022, 2'd1, 1'b0, 32'h00000004, "wrap_b1022"},
          '{32'd1023, 2'd1, 1'b0, 32'h00000003, "wrap_b1023"},
          '{32'd0, 2'd1, 1'b0, 32'h00000002, "wrap_b0"},
          '{32'd1, 2'd1, 1'b0, 32'h00000001, "wrap_b1"},
          '{32'd1022, 2'd3, 1'b0, 32'h01020304, "wrap_lw1022"}};
    run_table(t);
  endtask

  task automatic test_rdw_reset();
    // Read-during-write: old value before the edge, new value after.
    @(negedge SYS_clk);
    MEM_write_address = 32'd32;
    MEM_write_data    = 32'h13572468;
    MEM_write_length  = 2'd3;
    MEM_read_address  = 32'd32;
    MEM_read_length   = 2'd3;
    MEM_read_signed   = 1'b0;
    #1;
    checks++;
    if (MEM_read_data !== 32'h0) begin
      errors++;
      $display("FAIL rdw_before_edge: got %08h expected 00000000", MEM_read_data);
    end
    @(posedge SYS_clk);
    #1;
    checks++;
    if (MEM_read_data !== 32'h13572468) begin
      errors++;
      $display("FAIL rdw_after_edge: got %08h expected 13572468", MEM_read_data);
    end
    // Reset between edges with a write still requested.
    @(negedge SYS_clk);
    MEM_write_data = 32'hFFFFFFFF;
    #2;
    SYS_reset = 1'b0;
    #1;
    checks++;
    if (MEM_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_async_clear: got %08h expected 00000000", MEM_read_data);
    end
    MEM_read_address = 32'd8;
    #1;
    checks++;
    if (MEM_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_clear_lw8: got %08h expected 00000000", MEM_read_data);
    end
    MEM_read_address = 32'd32;
    @(posedge SYS_clk);
    #1;
    checks++;
    if (MEM_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_edge_no_write: got %08h expected 00000000", MEM_read_data);
    end
    @(negedge SYS_clk);
    MEM_write_length = 2'd0;
    SYS_reset = 1'b1;
    #1;
    checks++;
    if (MEM_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: got %08h expected 00000000", MEM_read_data);
    end
    model_clear();
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp;
    logic [1:0]  len;
    logic        sgn;
    for (int it = 0; it < 300; it++) begin
      a = (it % 4 == 0) ? 32'(1020 + $urandom_range(0, 7)) : $urandom;
      d = $urandom;
      len = 2'($urandom_range(0, 3));
      do_store(a, d, len);
      for (int r = 0; r < 2; r++) begin
        a = (r == 0) ? MEM_write_address + 32'($urandom_range(0, 3)) : $urandom;
        len = 2'($urandom_range(0, 3));
        sgn = 1'($urandom_range(0, 1));
        set_read(a, len, sgn);
        exp = model_load(a, len, sgn);
        checks++;
        if (MEM_read_data !== exp) begin
          errors++;
          $display("FAIL random_read a=%08h len=%0d s=%0b: got %08h expected %08h",
                   a, len, sgn, MEM_read_data, exp);
        end
      end
    end
  endtask

  initial begin
    SYS_reset         = 1'b0;
    MEM_write_length  = 2'd0;
    MEM_read_length   = 2'd0;
    MEM_read_signed   = 1'b0;
    MEM_write_data    = 32'h0;
    MEM_write_address = 32'h0;
    MEM_read_address  = 32'h0;
    test_reset();
    test_word_narrow();
    test_sign_ext();
    test_partial();
    test_alias_wrap();
    test_rdw_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressable, little-endian data memory for the single-cycle RISC-V core.
- Serves load and store traffic from the datapath: one combinational read port and one clocked write port.
- Read port supports byte, half and word accesses, with sign or zero extension.
- Write port supports byte, half and word stores.

Parameters:
- DEPTH_BYTES, 1024, storage size in bytes; must be a power of two.
- ADDR_BITS, 10, equal to log2(DEPTH_BYTES); low address bits used for indexing.

Ports:
- SYS_clk  input  1  system clock; writes occur on the rising edge.
- SYS_reset  input  1  asynchronous, active-low reset; clears the whole array.
- MEM_write_length  input  2  store size: 0 = no write, 1 = byte, 2 = half, 3 = word.
- MEM_read_length  input  2  load size: 1 = byte, 2 = half, 3 = word, 0 = read returns 0.
- MEM_read_signed  input  1  1 = sign-extend byte/half loads; 0 = zero-extend.
- MEM_write_data  input  32  store data; the low bytes are used for narrow stores.
- MEM_write_address  input  32  store byte address.
- MEM_read_address  input  32  load byte address.
- MEM_read_data  output  32  load result.

Behaviour:
- Storage: DEPTH_BYTES x 8-bit array.
  - Byte index = address[ADDR_BITS-1:0]; upper address bits are ignored (aliasing).
  - Each further byte of a multi-byte access uses (index+k) mod DEPTH_BYTES, so accesses wrap around the array.
- Reset:
  - While SYS_reset = 0, all bytes are 0, asynchronously.
  - MEM_read_data therefore reads 0 for any length.
  - Writes are ignored while reset is asserted.
  - Reset mid-operation discards the pending write.
- Write, on the rising edge of SYS_clk with SYS_reset = 1:
  - Length 1: byte[a] <= data[7:0].
  - Length 2: additionally byte[a+1] <= data[15:8].
  - Length 3: additionally byte[a+2] <= data[23:16] and byte[a+3] <= data[31:24].
  - Length 0: no change.
  - Bytes outside the addressed span are untouched.
- Read, combinational, zero latency:
  - Word = {b[a+3], b[a+2], b[a+1], b[a]}.
  - Half = {b[a+1], b[a]}, extended to 32 bits per MEM_read_signed.
  - Byte = b[a], extended to 32 bits per MEM_read_signed.
  - MEM_read_signed is ignored for word reads.
- Read-during-write at the same address:
  - Before the edge, the read returns the old contents.
  - The new contents are visible immediately after the edge. There is no bypass.
- Misaligned accesses are legal and performed bytewise, unless MISALIGN_TRAP_EN is defined.
- No X propagation: every output bit is driven from storage or constant 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined, add output port MEM_misaligned (1 bit), combinational.
  - It asserts when a read or write is misaligned: a half access with address[0] = 1, or a word access with address[1:0] != 0.
  - The read port is only checked when MEM_read_length != 0; the write port only when MEM_write_length != 0.
  - A misaligned write is suppressed.
  - A misaligned read returns 0.
- When undefined, the port is absent and misaligned accesses behave as described in Behaviour.

Decomposition:
- Shared package rv_mem_pkg holds:
  - Length encodings: LEN_NONE = 0, LEN_BYTE = 1, LEN_HALF = 2, LEN_WORD = 3.
  - DEPTH_BYTES default.
- One natural sub-module, load_extend: takes the raw 32-bit gathered bytes, the length and the signed flag, and produces the extended read value. It is reused by the core's load path.

Test Plan:
- Reset test: hold SYS_reset = 0, then release. A word read at addresses 0, 4 and 1020 returns 0x00000000.
- Word store and narrow loads: store word 0x12345678 at 8.
  - lw 8 -> 0x12345678.
  - lbu 8 -> 0x00000078.
  - lbu 11 -> 0x00000012.
  - lhu 10 -> 0x00001234.
- Sign extension: store byte 0x80 at 4.
  - lb 4 -> 0xFFFFFF80; lbu 4 -> 0x00000080.
  - Store half 0xBEEF at 6: lh 6 -> 0xFFFFBEEF, lhu 6 -> 0x0000BEEF, and lw 4 -> 0xBEEF0080.
- Partial-write isolation: after writing word 0xAABBCCDD at 16, store byte 0x11 at 17 -> lw 16 = 0xAABB11DD. A store with MEM_write_length = 0 leaves the word unchanged.
- Aliasing and wrap: store word 0xCAFEF00D at address 1024+8 -> lw 8 = 0xCAFEF00D.
  - Store word 0x01020304 at 1022 -> byte 1022 = 0x04, byte 1023 = 0x03, byte 0 = 0x02, byte 1 = 0x01.
- Reset mid-operation and read-during-write:
  - With write enabled, the read port on the same address shows the old value until the edge and the new value after it.
  - Asserting SYS_reset between edges clears the array immediately; the next edge performs no write while reset is held.
